// File: rtl/mult_pkg.sv
// Shared constants for the 8x8 shift-and-add multiplier: operand/product
// widths, iteration counter width and the FSM state encoding.
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 3;

  // The counter value seen at the last of the OP_W iterations
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage : mult_pkg

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups.
// Each group computes all of its internal carries directly from
// generate/propagate terms; the group carry feeds the upper group.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Flat two-level carry equations for one 4-bit group; c_out[0] is the
  // carry into bit 1, c_out[3] is the group carry-out.
  function automatic logic [3:0] group_carry(input logic [3:0] gg,
                                              input logic [3:0] pp,
                                              input logic       ci);
    logic [3:0] c_out;
    c_out[0] = gg[0] | (pp[0] & ci);
    c_out[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    c_out[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
             | (pp[2] & pp[1] & pp[0] & ci);
    c_out[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
             | (pp[3] & pp[2] & pp[1] & gg[0])
             | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
    return c_out;
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  // Carry network: low group from cin, high group from the low group carry
  always_comb begin
    c[0]   = cin;
    c[4:1] = group_carry(g[3:0], p[3:0], c[0]);
    c[8:5] = group_carry(g[7:4], p[7:4], c[4]);
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule : cla_8bit

// File: rtl/mult_shift_add_8bit.sv
// Sequential unsigned 8x8 multiplier. One add-and-shift step per clock
// over 8 RUN cycles, then a one-cycle DONE pulse. The partial-product
// register P holds the running high half in P[15:8] and the not-yet-
// consumed multiplier bits in P[7:0]; each step shifts the adder
// carry-out into P[15] so no carry is lost.
module mult_shift_add_8bit
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              done
);

  logic [1:0]        state;
  logic [OP_W-1:0]   a_reg;
  logic [PROD_W-1:0] p_reg;
  logic [CNT_W-1:0]  cnt;

  logic [OP_W-1:0]   addend;
  logic [OP_W-1:0]   sum;
  logic              carry;
  logic [PROD_W-1:0] p_next;

  // Add the multiplicand into the high half only when the current
  // multiplier bit (P[0]) is set.
  assign addend = p_reg[0] ? a_reg : '0;

  cla_8bit u_cla (
    .a    (p_reg[PROD_W-1:OP_W]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  assign p_next = {carry, sum, p_reg[OP_W-1:1]};

  // FSM, operand capture, shift register, counter and product register
  always_ff @(posedge clk) begin
    // NOTE: all state updates are non-blocking so every register samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      p_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            p_reg <= {{OP_W{1'b0}}, b};
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          p_reg <= p_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            product <= p_next;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule : mult_shift_add_8bit

// File: tb/tb_mult_shift_add_8bit.sv
// Directed and random checks for the shift-and-add multiplier, plus a
// cycle monitor for busy/done exclusivity, done width and product stability.
module tb_mult_shift_add_8bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  mult_shift_add_8bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until done is seen; n returns edges waited
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) check({tag, "_timeout"}, 16'd0, 16'd1);
  endtask

  // One complete multiply from IDLE, with latency and result checks
  task automatic run_op(input string tag, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp);
    int n;
    a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tag, n);
    check({tag, "_lat"}, 16'(n), 16'd8);
    check({tag, "_prod"}, product, exp);
    tick();
    check({tag, "_done_fall"}, {15'd0, done}, 16'd0);
  endtask

  // Cycle monitor
  logic        armed = 1'b0;
  logic        rst_at_edge = 1'b0;
  logic        prev_done = 1'b0;
  logic [15:0] prev_prod = 16'd0;

  always @(posedge clk) rst_at_edge = rst;

  always @(negedge clk) begin
    if (armed) begin
      check("busy_done_excl", {15'd0, busy & done}, 16'd0);
      if (done) check("done_width", {15'd0, prev_done}, 16'd0);
      if (product !== prev_prod)
        check("prod_stable", {15'd0, done | rst_at_edge}, 16'd1);
    end
    prev_done = done;
    prev_prod = product;
  end

  initial begin
    int n;
    int m;
    int busy_cnt;
    logic [7:0] x;
    logic [7:0] y;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("rst_prod", product, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);

    // Reset wins over start on the same edge
    start = 1'b1; a = 8'd9; b = 8'd9;
    tick();
    check("rst_prio_busy", {15'd0, busy}, 16'd0);
    start = 1'b0; rst = 1'b0;
    tick();
    check("idle_hold_busy", {15'd0, busy}, 16'd0);
    armed = 1'b1;

    // 13*11 with detailed busy/done timing
    a = 8'd13; b = 8'd11; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'hFF; b = 8'hFF;          // post-acceptance change is ignored
    busy_cnt = 0; n = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    check("t13_lat", 16'(n), 16'd8);
    check("t13_busy_cycles", 16'(busy_cnt), 16'd8);
    check("t13_prod", product, 16'h008F);
    check("t13_busy_in_done", {15'd0, busy}, 16'd0);
    tick();
    check("t13_done_fall", {15'd0, done}, 16'd0);
    check("t13_prod_hold", product, 16'h008F);

    // Boundaries
    run_op("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
    run_op("a0", 8'h00, 8'hA5, 16'h0000);
    run_op("b0", 8'hA5, 8'h00, 16'h0000);
    run_op("one_ff", 8'h01, 8'hFF, 16'h00FF);
    run_op("80_80", 8'h80, 8'h80, 16'h4000);

    // start held high: back-to-back 3*5 then 7*9
    a = 8'd3; b = 8'd5; start = 1'b1;
    tick();
    a = 8'd7; b = 8'd9;
    wait_done("b2b1", n);
    check("b2b1_prod", product, 16'd15);
    m = 0;
    do begin
      tick();
      m++;
      if (m == 2) begin
        check("b2b2_accept", {15'd0, busy}, 16'd1);
        a = 8'hEE; b = 8'hEE; start = 1'b0;
      end
    end while (!done && m < 40);
    check("b2b_spacing", 16'(m), 16'd10);
    check("b2b2_prod", product, 16'd63);
    tick();

    // Reset in the 4th RUN cycle of 200*100
    a = 8'd200; b = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_pre", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_done", {15'd0, done}, 16'd0);
    check("abort_prod", product, 16'h0000);
    m = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) m++;
      tick();
    end
    check("abort_no_done", 16'(m), 16'd0);
    run_op("after_abort", 8'd200, 8'd100, 16'h4E20);

    // Random sweep against a*b
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
      wait_done("rnd", n);
      check("rnd_prod", product, 16'(x) * 16'(y));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mult_shift_add_8bit
